// File: rtl/cpu_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cpu_port_arbiter
// Brief    : Packet-granular round-robin arbiter feeding cpu_header_add; stamps
//            the source port into tuser and counts forwarded packets per port.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_port_arbiter #(
    parameter int C_NUM_PORTS    = 4,
    parameter int C_DATA_WIDTH   = 256,
    parameter int C_TUSER_WIDTH  = 128,
    parameter int C_SRC_PORT_LSB = 64
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [C_NUM_PORTS*C_DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [C_NUM_PORTS*C_TUSER_WIDTH-1:0]    s_axis_tuser,
    input  logic [C_NUM_PORTS*C_DATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic [C_NUM_PORTS-1:0]                  s_axis_tvalid,
    input  logic [C_NUM_PORTS-1:0]                  s_axis_tlast,
    output logic [C_NUM_PORTS-1:0]                  s_axis_tready,
    output logic [C_DATA_WIDTH-1:0]                 m_axis_tdata,
    output logic [C_TUSER_WIDTH-1:0]                m_axis_tuser,
    output logic [C_DATA_WIDTH/8-1:0]               m_axis_tkeep,
    output logic                                    m_axis_tvalid,
    output logic                                    m_axis_tlast,
    input  logic                                    m_axis_tready,
    output logic [C_NUM_PORTS*32-1:0]               pkt_cnt
);

    localparam int C_PW = $clog2(C_NUM_PORTS);
    localparam int C_KW = C_DATA_WIDTH / 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [C_PW-1:0]          r_grant;
    logic [C_PW-1:0]          w_grant_nxt;
    logic [C_PW-1:0]          r_last;
    logic [C_PW-1:0]          w_last_nxt;
    logic [C_PW-1:0]          w_rr_pick;
    logic [C_PW-1:0]          w_idx;
    logic                     w_rr_found;

    logic [C_DATA_WIDTH-1:0]  w_port_tdata [C_NUM_PORTS];
    logic [C_TUSER_WIDTH-1:0] w_port_tuser [C_NUM_PORTS];
    logic [C_KW-1:0]          w_port_tkeep [C_NUM_PORTS];

    logic [C_DATA_WIDTH-1:0]  w_sel_tdata;
    logic [C_TUSER_WIDTH-1:0] w_sel_tuser;
    logic [C_TUSER_WIDTH-1:0] w_stamped_tuser;
    logic [C_KW-1:0]          w_sel_tkeep;
    logic                     w_sel_tlast;
    logic                     w_out_free;
    logic                     w_accept;
    logic                     w_eop;

    logic [C_DATA_WIDTH-1:0]  r_m_tdata;
    logic [C_TUSER_WIDTH-1:0] r_m_tuser;
    logic [C_KW-1:0]          r_m_tkeep;
    logic                     r_m_tvalid;
    logic                     r_m_tlast;

    for (genvar gi = 0; gi < C_NUM_PORTS; gi++) begin : g_unpack
        assign w_port_tdata[gi] = s_axis_tdata[gi*C_DATA_WIDTH +: C_DATA_WIDTH];
        assign w_port_tuser[gi] = s_axis_tuser[gi*C_TUSER_WIDTH +: C_TUSER_WIDTH];
        assign w_port_tkeep[gi] = s_axis_tkeep[gi*C_KW +: C_KW];
    end

    assign w_sel_tdata = w_port_tdata[r_grant];
    assign w_sel_tuser = w_port_tuser[r_grant];
    assign w_sel_tkeep = w_port_tkeep[r_grant];
    assign w_sel_tlast = s_axis_tlast[r_grant];

    assign w_out_free  = !r_m_tvalid || m_axis_tready;
    assign w_accept    = (r_state == ST_GRANT) && w_out_free && s_axis_tvalid[r_grant];
    assign w_eop       = w_accept && w_sel_tlast;

    always_comb begin
        s_axis_tready = '0;
        if ((r_state == ST_GRANT) && w_out_free) begin
            s_axis_tready[r_grant] = 1'b1;
        end
    end

    // Search starts one past the most recent winner so every port gets a turn.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_pick  = r_last;
        w_idx      = r_last;
        for (int k = 1; k <= C_NUM_PORTS; k++) begin
            w_idx = C_PW'((int'(r_last) + k) % C_NUM_PORTS);
            if (!w_rr_found && s_axis_tvalid[w_idx]) begin
                w_rr_found = 1'b1;
                w_rr_pick  = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (|s_axis_tvalid) begin
                    w_state_nxt = ST_GRANT;
                    w_grant_nxt = w_rr_pick;
                end
            end
            ST_GRANT: begin
                if (w_eop) begin
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = r_grant;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_last  <= C_PW'(C_NUM_PORTS - 1);
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_stamped_tuser = w_sel_tuser;
        w_stamped_tuser[C_SRC_PORT_LSB +: C_PW] = r_grant;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tuser  <= '0;
            r_m_tkeep  <= '0;
            r_m_tlast  <= 1'b0;
        end else if (w_accept) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= w_sel_tdata;
            r_m_tuser  <= w_stamped_tuser;
            r_m_tkeep  <= w_sel_tkeep;
            r_m_tlast  <= w_sel_tlast;
        end else if (w_out_free) begin
            r_m_tvalid <= 1'b0;
        end
    end

    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tuser  = r_m_tuser;
    assign m_axis_tkeep  = r_m_tkeep;
    assign m_axis_tlast  = r_m_tlast;

    for (genvar gi = 0; gi < C_NUM_PORTS; gi++) begin : g_cnt
        logic [31:0] r_cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (w_eop && (r_grant == C_PW'(gi))) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
        assign pkt_cnt[gi*32 +: 32] = r_cnt;
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_port_arbiter
// Brief    : Directed scoreboard bench for cpu_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_port_arbiter;

    localparam int NP   = 4;
    localparam int DW   = 256;
    localparam int UW   = 128;
    localparam int KW   = DW / 8;
    localparam int SLSB = 64;
    localparam int PW   = 2;

    localparam logic [UW-1:0] USER_A = {32{4'ha}};
    localparam logic [UW-1:0] USER_B = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP*DW-1:0]  s_axis_tdata;
    logic [NP*UW-1:0]  s_axis_tuser;
    logic [NP*KW-1:0]  s_axis_tkeep;
    logic [NP-1:0]     s_axis_tvalid;
    logic [NP-1:0]     s_axis_tlast;
    logic [NP-1:0]     s_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic [UW-1:0]     m_axis_tuser;
    logic [KW-1:0]     m_axis_tkeep;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready;
    logic [NP*32-1:0]  pkt_cnt;

    beat_t       src_q [NP][$];
    beat_t       exp_q [$];
    int          acc_log [$];
    bit          log_en;
    int          cyc;
    logic [NP-1:0] hs_n;
    int          total;
    int          bad;

    cpu_port_arbiter #(
        .C_NUM_PORTS    (NP),
        .C_DATA_WIDTH   (DW),
        .C_TUSER_WIDTH  (UW),
        .C_SRC_PORT_LSB (SLSB)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .pkt_cnt       (pkt_cnt)
    );

    initial forever #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        hs_n = '0;
        forever begin
            @(negedge clk);
            hs_n = s_axis_tvalid & s_axis_tready;
        end
    end

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input int p, input int id, input int bt);
        logic [31:0] w;
        w = 32'hD000_0000 | (p << 16) | (id << 8) | bt;
        return {(DW/32){w}};
    endfunction

    // Queue a source packet; the expected output copy carries the stamped port.
    task automatic send_pkt(input int port, input int pid, input int nb,
                            input logic [UW-1:0] user, input logic [KW-1:0] lkeep,
                            input bit exp_out);
        beat_t b;
        beat_t e;
        for (int k = 0; k < nb; k++) begin
            b.data = mk_data(port, pid, k);
            b.user = user;
            b.keep = (k == nb - 1) ? lkeep : '1;
            b.last = (k == nb - 1);
            src_q[port].push_back(b);
            e = b;
            e.user[SLSB +: PW] = PW'(port);
            if (exp_out) exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input string nm);
        int  n;
        bit  done;
        bit  src_empty;
        n    = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            src_empty = 1;
            for (int i = 0; i < NP; i++) if (src_q[i].size() != 0) src_empty = 0;
            done = src_empty && (exp_q.size() == 0) && !m_axis_tvalid;
            n++;
            if (!done && n > 300) begin
                total++;
                bad++;
                $display("FAIL %s: drain timed out with %0d output beats outstanding", nm, exp_q.size());
                for (int i = 0; i < NP; i++) src_q[i].delete();
                exp_q.delete();
                done = 1;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Source driver: retire beats that handshook at the previous edge, present the next.
    initial begin
        beat_t b;
        s_axis_tdata  = '0;
        s_axis_tuser  = '0;
        s_axis_tkeep  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NP; i++) begin
                if (hs_n[i] && src_q[i].size() > 0) begin
                    void'(src_q[i].pop_front());
                    if (log_en) acc_log.push_back(cyc);
                end
                if (src_q[i].size() > 0) begin
                    b = src_q[i][0];
                    s_axis_tvalid[i]          = 1'b1;
                    s_axis_tdata[i*DW +: DW]  = b.data;
                    s_axis_tuser[i*UW +: UW]  = b.user;
                    s_axis_tkeep[i*KW +: KW]  = b.keep;
                    s_axis_tlast[i]           = b.last;
                end else begin
                    s_axis_tvalid[i] = 1'b0;
                    s_axis_tlast[i]  = 1'b0;
                end
            end
        end
    end

    // Output monitor: scoreboard pop on handshake, hold check while stalled.
    initial begin
        logic [DW+UW+KW:0] held;
        bit                stalled;
        beat_t             e;
        stalled = 0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (rst_n && m_axis_tvalid) begin
                if (stalled)
                    chk("hold_stable", {m_axis_tdata, m_axis_tuser, m_axis_tkeep, m_axis_tlast}, held);
                if (!m_axis_tready) begin
                    chk("src_ready_while_full", s_axis_tready, '0);
                    held    = {m_axis_tdata, m_axis_tuser, m_axis_tkeep, m_axis_tlast};
                    stalled = 1;
                end else begin
                    stalled = 0;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL out_beat: got unexpected beat %0h expected none", m_axis_tdata[31:0]);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_tdata", m_axis_tdata, e.data);
                        chk("out_tuser", m_axis_tuser, e.user);
                        chk("out_tkeep", m_axis_tkeep, e.keep);
                        chk("out_tlast", m_axis_tlast, e.last);
                    end
                end
            end else begin
                stalled = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        total         = 0;
        bad           = 0;
        log_en        = 0;
        rst_n         = 1'b0;
        m_axis_tready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_tvalid", m_axis_tvalid, 0);
        chk("rst_m_tdata", m_axis_tdata, 0);
        chk("rst_s_tready", s_axis_tready, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Single port, 3-beat packet with arbitration latency
        send_pkt(2, 0, 3, USER_A, 32'hffff_0000, 1);
        @(negedge clk);
        chk("t1_idle_out", m_axis_tvalid, 0);
        @(negedge clk);
        chk("t1_grant_ready", s_axis_tready, 4'b0100);
        chk("t1_out_not_yet", m_axis_tvalid, 0);
        @(negedge clk);
        chk("t1_first_out", m_axis_tvalid, 1);
        wait_drain("t1");
        chk("t1_cnt2", pkt_cnt[2*32 +: 32], 1);
        chk("t1_cnt0", pkt_cnt[0 +: 32], 0);

        // All ports busy: strict rotation with a single idle arbitration cycle
        do_reset();
        acc_log.delete();
        log_en = 1;
        for (int pk = 0; pk < 2; pk++)
            for (int p = 0; p < NP; p++)
                send_pkt(p, pk, 2, USER_B, 32'h0000_00ff, 1);
        wait_drain("t2");
        log_en = 0;
        chk("t2_accepts", acc_log.size(), 16);
        if (acc_log.size() == 16)
            for (int k = 1; k < 16; k++)
                chk($sformatf("t2_gap%0d", k), acc_log[k] - acc_log[k-1], (k % 2 == 1) ? 1 : 2);
        for (int p = 0; p < NP; p++)
            chk($sformatf("t2_cnt%0d", p), pkt_cnt[p*32 +: 32], 2);

        // Output backpressure
        send_pkt(1, 0, 3, USER_B, 32'h0f0f_0f0f, 1);
        repeat (12) begin
            @(posedge clk);
            #2 m_axis_tready = ~m_axis_tready;
        end
        m_axis_tready = 1'b1;
        wait_drain("t3");
        chk("t3_cnt1", pkt_cnt[1*32 +: 32], 3);

        // Grant lock: port 1 requests while port 0 is mid-packet
        send_pkt(0, 1, 3, USER_B, 32'hffff_ffff, 1);
        repeat (3) @(negedge clk);
        send_pkt(1, 1, 2, USER_B, 32'h0000_ffff, 1);
        @(negedge clk);
        chk("t4_lock_mid", s_axis_tready, 4'b0001);
        @(negedge clk);
        chk("t4_lock_idle", s_axis_tready[1], 0);
        @(negedge clk);
        chk("t4_next_grant", s_axis_tready, 4'b0010);
        wait_drain("t4");
        chk("t4_cnt0", pkt_cnt[0 +: 32], 3);
        chk("t4_cnt1", pkt_cnt[1*32 +: 32], 4);

        // Reset during beat 2 of 3 on port 2; the in-flight beat is discarded
        send_pkt(2, 1, 3, USER_B, 32'hffff_ffff, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        src_q[2].delete();
        #1;
        chk("t5_m_tvalid", m_axis_tvalid, 0);
        chk("t5_m_tdata", m_axis_tdata, 0);
        chk("t5_m_tuser", m_axis_tuser, 0);
        chk("t5_m_tkeep", m_axis_tkeep, 0);
        chk("t5_s_tready", s_axis_tready, 0);
        chk("t5_pkt_cnt", pkt_cnt, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        send_pkt(0, 2, 1, USER_B, 32'h0000_0001, 1);
        send_pkt(3, 2, 1, USER_B, 32'h0000_0003, 1);
        repeat (2) @(negedge clk);
        chk("t5_first_grant", s_axis_tready, 4'b0001);
        wait_drain("t5");
        chk("t5_cnt0", pkt_cnt[0 +: 32], 1);
        chk("t5_cnt3", pkt_cnt[3*32 +: 32], 1);

        // Counter wrap
        force dut.g_cnt[0].r_cnt = 32'hffff_ffff;
        @(negedge clk);
        release dut.g_cnt[0].r_cnt;
        chk("t6_preset", pkt_cnt[0 +: 32], 32'hffff_ffff);
        send_pkt(0, 3, 1, USER_B, 32'h8000_0000, 1);
        wait_drain("t6");
        chk("t6_wrap", pkt_cnt[0 +: 32], 0);
        chk("t6_cnt3", pkt_cnt[3*32 +: 32], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_port_arbiter.md
# cpu_port_arbiter

Packet-granular round-robin arbiter sharing the CPU-bound header-insertion path among C_NUM_PORTS switch-port AXI-Stream sources. It sits directly upstream of cpu_header_add. It selects one source packet at a time, stamps the source port index into the tuser metadata, and forwards the packet through a one-deep output register. Per-port forwarded-packet counters are exposed for the management CPU.

## Interface
- C_NUM_PORTS, 4: number of requesting sources, 2..8.
- C_DATA_WIDTH, 256: tdata width.
- C_TUSER_WIDTH, 128: tuser width.
- C_SRC_PORT_LSB, 64: LSB of the source-port field inside tuser. Field width is PW = clog2(C_NUM_PORTS).
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  C_NUM_PORTS*C_DATA_WIDTH  flattened; port i occupies slice i.
- s_axis_tuser  in  C_NUM_PORTS*C_TUSER_WIDTH  flattened metadata.
- s_axis_tkeep  in  C_NUM_PORTS*C_DATA_WIDTH/8  flattened byte enables.
- s_axis_tvalid  in  C_NUM_PORTS  per-port valid.
- s_axis_tlast  in  C_NUM_PORTS  per-port last.
- s_axis_tready  out  C_NUM_PORTS  per-port ready.
- m_axis_tdata  out  C_DATA_WIDTH  to cpu_header_add.
- m_axis_tuser  out  C_TUSER_WIDTH  source tuser with the port field overwritten.
- m_axis_tkeep  out  C_DATA_WIDTH/8.
- m_axis_tvalid  out  1.
- m_axis_tlast  out  1.
- m_axis_tready  in  1.
- pkt_cnt  out  C_NUM_PORTS*32  per-port count of packets whose tlast beat was accepted.

## Operation
- FSM states:
  - IDLE: no packet in flight.
  - GRANT: a packet is in flight from port `grant`.
- Transition IDLE -> GRANT:
  - Occurs when any s_axis_tvalid bit is 1.
  - `grant` takes the first valid port found searching from (last+1) mod C_NUM_PORTS upward, with wrap.
  - `last` is the port granted most recently.
- Transition GRANT -> IDLE: on the cycle the granted port's tlast beat is accepted. `last` <= grant on that same cycle.
- The grant is locked for the whole packet. Other ports' tvalid is ignored until tlast of the current packet.
- Backpressure rule:
  - out_free = !m_axis_tvalid || m_axis_tready.
  - s_axis_tready[i] = (state == GRANT) && (grant == i) && out_free. All other bits are 0.
- Beat accept (granted port's tvalid && tready):
  - Output register loads tdata, tkeep and tlast unchanged.
  - It loads tuser with bits [C_SRC_PORT_LSB +: PW] replaced by grant; all other bits pass through.
  - m_axis_tvalid <= 1.
- If out_free holds and no beat is accepted that cycle, m_axis_tvalid <= 0.
- Counters: pkt_cnt[i] += 1 on acceptance of port i's tlast beat. 32-bit, wraps 0xFFFFFFFF -> 0, no saturation.
- Single-beat packets (tlast on the first beat) are legal: GRANT lasts one accepted beat.
- A source dropping tvalid mid-packet keeps the grant. The arbiter waits indefinitely in GRANT.
- Reset (asserted at any time, including mid-packet):
  - State forced to IDLE, `last` = C_NUM_PORTS-1, so port 0 wins first.
  - All outputs 0: m_axis_* = 0, s_axis_tready = 0, pkt_cnt = 0.
  - Any in-flight output beat is discarded.

## Timing
- Arbitration: 1 cycle.
  - tvalid seen in IDLE at edge N gives GRANT at N+1.
  - The first beat can be accepted in the cycle following edge N+1.
- Datapath latency: 1 cycle. A beat accepted at edge K is presented on m_axis from K onward, with valid high after K.
- Throughput: 1 beat/cycle within a packet while m_axis_tready = 1. The output register is a pipeline stage with no bubble.
- Inter-packet gap: exactly 1 idle input cycle (the IDLE arbitration cycle) between the tlast acceptance and the next packet's first acceptance.
- m_axis_* hold stable while m_axis_tvalid && !m_axis_tready.
- pkt_cnt updates on the same edge as tlast acceptance and is visible the cycle after.
- Port 0 index occupies slice [C_DATA_WIDTH-1:0] of flattened buses.

## Test plan
- Single port, 3-beat packet:
  - Stimulus: port 2 only, tuser = 128'haaaa..., last beat tkeep = 32'hffff0000.
  - Required: m_axis carries the 3 beats unchanged except tuser[65:64] = 2'd2; tkeep preserved; pkt_cnt[2] = 1; the first output beat appears 2 cycles after tvalid rises.
- All 4 ports continuously valid with 2-beat packets:
  - Required grant order 0,1,2,3,0,1,...; each packet contiguous on m_axis; exactly one idle input cycle between packets; after 8 packets every pkt_cnt = 2.
- Backpressure:
  - Stimulus: m_axis_tready toggles 1,0,1,0 during a 3-beat packet.
  - Required: no beat lost or duplicated; m_axis data stable while stalled; s_axis_tready of the granted port low whenever the output register is full and not draining.
- Grant lock:
  - Stimulus: port 1 asserts tvalid while port 0's packet is mid-flight.
  - Required: s_axis_tready[1] = 0 until port 0's tlast is accepted; port 1 granted next.
- Reset mid-packet:
  - Stimulus: assert rst_n = 0 during beat 2 of 3.
  - Required: all outputs 0 immediately (asynchronously); after release, ports 0 and 3 both valid -> port 0 granted first.
- Counter wrap:
  - Stimulus: force pkt_cnt[0] to 32'hffffffff, then send one single-beat packet on port 0.
  - Required: pkt_cnt[0] = 0.
